// File: rtl/mips_cpu_pkg.sv
// mips_cpu_pkg
// Shared definitions for the ALU issue slice:
//   - alu_op_e  : ALU operation codes, values match the mips_cpu_ALU encoding
//   - OP_* / FN_* : MIPS32 primary opcodes and R-type funct codes handled here
//   - wb_rec_t  : writeback record {rd, data, zero}
//   - sext16 / zext16 : immediate extension helpers
package mips_cpu_pkg;

    typedef enum logic [4:0] {
        ALU_AND    = 5'd0,
        ALU_OR     = 5'd1,
        ALU_ADD    = 5'd2,
        ALU_SUB    = 5'd3,
        ALU_SLT    = 5'd4,
        ALU_XOR    = 5'd5,
        ALU_SLL    = 5'd6,
        ALU_SRL    = 5'd7,
        ALU_SRA    = 5'd8,
        ALU_SLLV   = 5'd9,
        ALU_SRLV   = 5'd10,
        ALU_SRAV   = 5'd11,
        ALU_LUI    = 5'd12,
        ALU_SLTU   = 5'd13,
        ALU_NOR    = 5'd14,
        ALU_PASS_B = 5'd15
    } alu_op_e;

    // Primary opcodes
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_SLTIU = 6'h0B;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F;

    // R-type funct codes
    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_SRA  = 6'h03;
    localparam logic [5:0] FN_SLLV = 6'h04;
    localparam logic [5:0] FN_SRLV = 6'h06;
    localparam logic [5:0] FN_SRAV = 6'h07;
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_XOR  = 6'h26;
    localparam logic [5:0] FN_SLT  = 6'h2A;
    localparam logic [5:0] FN_SLTU = 6'h2B;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
        logic        zero;
    } wb_rec_t;

    function automatic logic [31:0] sext16(input logic [15:0] imm);
        return {{16{imm[15]}}, imm};
    endfunction

    function automatic logic [31:0] zext16(input logic [15:0] imm);
        return {16'h0000, imm};
    endfunction

endpackage

// File: rtl/mips_cpu_alu_decode.sv
// mips_cpu_alu_decode
// Combinational map from an ALU-class MIPS32 instruction plus its register
// operands to the ALU command.
//   i_instr    : instruction word
//   i_rs_data  : GPR[rs] value
//   i_rt_data  : GPR[rt] value
//   o_op       : ALU operation
//   o_a, o_b   : ALU operands
//   o_sa       : constant shift amount
//   o_dest     : destination GPR index
//   o_legal    : instruction is one of the supported ALU-class forms
module mips_cpu_alu_decode
    import mips_cpu_pkg::*;
(
    input  logic [31:0] i_instr,
    input  logic [31:0] i_rs_data,
    input  logic [31:0] i_rt_data,
    output alu_op_e     o_op,
    output logic [31:0] o_a,
    output logic [31:0] o_b,
    output logic [4:0]  o_sa,
    output logic [4:0]  o_dest,
    output logic        o_legal
);

    logic [5:0]  w_opcode;
    logic [5:0]  w_funct;
    logic [31:0] w_simm;
    logic [31:0] w_zimm;
    // The rs index is resolved by the register file upstream; only its value is used here.
    logic        w_unused_rs_field;

    assign w_opcode          = i_instr[31:26];
    assign w_funct           = i_instr[5:0];
    assign w_simm            = sext16(i_instr[15:0]);
    assign w_zimm            = zext16(i_instr[15:0]);
    assign w_unused_rs_field = ^i_instr[25:21];

    // Opcode/funct decode into ALU command, operands and destination
    always_comb begin
        o_op    = ALU_AND;
        o_a     = 32'd0;
        o_b     = 32'd0;
        o_sa    = 5'd0;
        o_dest  = i_instr[15:11];
        o_legal = 1'b0;
        case (w_opcode)
            OP_RTYPE: begin
                o_a     = i_rs_data;
                o_b     = i_rt_data;
                o_dest  = i_instr[15:11];
                o_legal = 1'b1;
                case (w_funct)
                    FN_ADD, FN_ADDU: o_op = ALU_ADD;
                    FN_SUB, FN_SUBU: o_op = ALU_SUB;
                    FN_AND:          o_op = ALU_AND;
                    FN_OR:           o_op = ALU_OR;
                    FN_XOR:          o_op = ALU_XOR;
                    FN_SLT:          o_op = ALU_SLT;
                    FN_SLTU:         o_op = ALU_SLTU;
                    // Constant shifts take the amount from the instruction; a is unused.
                    FN_SLL: begin o_op = ALU_SLL; o_a = 32'd0; o_sa = i_instr[10:6]; end
                    FN_SRL: begin o_op = ALU_SRL; o_a = 32'd0; o_sa = i_instr[10:6]; end
                    FN_SRA: begin o_op = ALU_SRA; o_a = 32'd0; o_sa = i_instr[10:6]; end
                    // Variable shifts: the ALU takes the amount from a[4:0].
                    FN_SLLV:         o_op = ALU_SLLV;
                    FN_SRLV:         o_op = ALU_SRLV;
                    FN_SRAV:         o_op = ALU_SRAV;
                    default:         o_legal = 1'b0;
                endcase
            end
            OP_ADDI, OP_ADDIU: begin
                o_op = ALU_ADD;  o_a = i_rs_data; o_b = w_simm;
                o_dest = i_instr[20:16]; o_legal = 1'b1;
            end
            OP_SLTI: begin
                o_op = ALU_SLT;  o_a = i_rs_data; o_b = w_simm;
                o_dest = i_instr[20:16]; o_legal = 1'b1;
            end
            OP_SLTIU: begin
                // Sign-extended, then compared unsigned by the ALU.
                o_op = ALU_SLTU; o_a = i_rs_data; o_b = w_simm;
                o_dest = i_instr[20:16]; o_legal = 1'b1;
            end
            OP_ANDI: begin
                o_op = ALU_AND;  o_a = i_rs_data; o_b = w_zimm;
                o_dest = i_instr[20:16]; o_legal = 1'b1;
            end
            OP_ORI: begin
                o_op = ALU_OR;   o_a = i_rs_data; o_b = w_zimm;
                o_dest = i_instr[20:16]; o_legal = 1'b1;
            end
            OP_XORI: begin
                o_op = ALU_XOR;  o_a = i_rs_data; o_b = w_zimm;
                o_dest = i_instr[20:16]; o_legal = 1'b1;
            end
            OP_LUI: begin
                o_op = ALU_LUI;  o_a = 32'd0;     o_b = w_zimm;
                o_dest = i_instr[20:16]; o_legal = 1'b1;
            end
            default: o_legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/mips_cpu_alu_issue.sv
// mips_cpu_alu_issue
// Decode-and-issue stage in front of the combinational mips_cpu_ALU.
// Stage 1 (issue register) drives the ALU; stage 2 (writeback register)
// captures the ALU result for the register file. Full back-pressure,
// one instruction per cycle.
//   i_clk, i_reset              : clock, synchronous active-high reset
//   i_instr_valid/o_instr_ready : instruction handshake
//   i_instr, i_rs_data, i_rt_data : instruction and operand values
//   o_alu_op/a/b/sa             : registered ALU command
//   i_alu_result, i_alu_zero    : ALU response (combinational from o_alu_*)
//   o_wb_valid/i_wb_ready       : writeback handshake
//   o_wb_reg/data/zero          : writeback record
//   o_illegal                   : one-cycle pulse after accepting a non-ALU instruction
module mips_cpu_alu_issue
    import mips_cpu_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_instr_valid,
    output logic        o_instr_ready,
    input  logic [31:0] i_instr,
    input  logic [31:0] i_rs_data,
    input  logic [31:0] i_rt_data,
    output logic [4:0]  o_alu_op,
    output logic [31:0] o_alu_a,
    output logic [31:0] o_alu_b,
    output logic [4:0]  o_alu_sa,
    input  logic [31:0] i_alu_result,
    input  logic        i_alu_zero,
    output logic        o_wb_valid,
    input  logic        i_wb_ready,
    output logic [4:0]  o_wb_reg,
    output logic [31:0] o_wb_data,
    output logic        o_wb_zero,
    output logic        o_illegal
);

    alu_op_e     w_dec_op;
    logic [31:0] w_dec_a;
    logic [31:0] w_dec_b;
    logic [4:0]  w_dec_sa;
    logic [4:0]  w_dec_dest;
    logic        w_dec_legal;
    logic        w_s1_adv;
    logic        w_accept;

    logic        r_s1_valid;
    alu_op_e     r_alu_op;
    logic [31:0] r_alu_a;
    logic [31:0] r_alu_b;
    logic [4:0]  r_alu_sa;
    logic [4:0]  r_s1_dest;
    logic        r_wb_valid;
    wb_rec_t     r_wb;
    logic        r_illegal;

    mips_cpu_alu_decode u_decode (
        .i_instr   (i_instr),
        .i_rs_data (i_rs_data),
        .i_rt_data (i_rt_data),
        .o_op      (w_dec_op),
        .o_a       (w_dec_a),
        .o_b       (w_dec_b),
        .o_sa      (w_dec_sa),
        .o_dest    (w_dec_dest),
        .o_legal   (w_dec_legal)
    );

    // s1 may move forward whenever the wb slot is free or being drained this cycle.
    assign w_s1_adv      = !r_wb_valid || i_wb_ready;
    assign o_instr_ready = !i_reset && (!r_s1_valid || w_s1_adv);
    assign w_accept      = i_instr_valid && o_instr_ready;

    // Issue register: loads legal accepted instructions, empties when it drains
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_s1_valid <= 1'b0;
            r_alu_op   <= ALU_AND;
            r_alu_a    <= 32'd0;
            r_alu_b    <= 32'd0;
            r_alu_sa   <= 5'd0;
            r_s1_dest  <= 5'd0;
        end else if (w_accept && w_dec_legal) begin
            r_s1_valid <= 1'b1;
            r_alu_op   <= w_dec_op;
            r_alu_a    <= w_dec_a;
            r_alu_b    <= w_dec_b;
            r_alu_sa   <= w_dec_sa;
            r_s1_dest  <= w_dec_dest;
        end else if (w_s1_adv) begin
            // Drained (or an illegal was consumed): ALU command holds, entry is gone.
            r_s1_valid <= 1'b0;
        end else begin
            r_s1_valid <= r_s1_valid;
        end
    end

    // Writeback register: captures the ALU response as s1 advances
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_wb_valid <= 1'b0;
            r_wb       <= '{rd: 5'd0, data: 32'd0, zero: 1'b0};
        end else if (r_s1_valid && w_s1_adv) begin
            r_wb_valid <= 1'b1;
            r_wb       <= '{rd: r_s1_dest, data: i_alu_result, zero: i_alu_zero};
        end else if (i_wb_ready) begin
            r_wb_valid <= 1'b0;
        end else begin
            r_wb_valid <= r_wb_valid;
        end
    end

    // Illegal-instruction pulse, one cycle after the accept
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_illegal <= 1'b0;
        end else begin
            r_illegal <= w_accept && !w_dec_legal;
        end
    end

    assign o_alu_op   = r_alu_op;
    assign o_alu_a    = r_alu_a;
    assign o_alu_b    = r_alu_b;
    assign o_alu_sa   = r_alu_sa;
    assign o_wb_valid = r_wb_valid;
    assign o_wb_reg   = r_wb.rd;
    assign o_wb_data  = r_wb.data;
    assign o_wb_zero  = r_wb.zero;
    assign o_illegal  = r_illegal;

endmodule

// File: tb/tb_mips_cpu_alu_issue.sv
// Testbench for mips_cpu_alu_issue: behavioural ALU, scoreboard of expected
// writeback records pushed at accept time and popped on each wb transfer.
module tb_mips_cpu_alu_issue;

    logic        clk;
    logic        i_reset;
    logic        i_instr_valid;
    logic        o_instr_ready;
    logic [31:0] i_instr;
    logic [31:0] i_rs_data;
    logic [31:0] i_rt_data;
    logic [4:0]  o_alu_op;
    logic [31:0] o_alu_a;
    logic [31:0] o_alu_b;
    logic [4:0]  o_alu_sa;
    logic [31:0] alu_res;
    logic        alu_zero;
    logic        o_wb_valid;
    logic        i_wb_ready;
    logic [4:0]  o_wb_reg;
    logic [31:0] o_wb_data;
    logic        o_wb_zero;
    logic        o_illegal;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
        logic        zero;
    } exp_t;
    exp_t sb[$];

    mips_cpu_alu_issue dut (
        .i_clk         (clk),
        .i_reset       (i_reset),
        .i_instr_valid (i_instr_valid),
        .o_instr_ready (o_instr_ready),
        .i_instr       (i_instr),
        .i_rs_data     (i_rs_data),
        .i_rt_data     (i_rt_data),
        .o_alu_op      (o_alu_op),
        .o_alu_a       (o_alu_a),
        .o_alu_b       (o_alu_b),
        .o_alu_sa      (o_alu_sa),
        .i_alu_result  (alu_res),
        .i_alu_zero    (alu_zero),
        .o_wb_valid    (o_wb_valid),
        .i_wb_ready    (i_wb_ready),
        .o_wb_reg      (o_wb_reg),
        .o_wb_data     (o_wb_data),
        .o_wb_zero     (o_wb_zero),
        .o_illegal     (o_illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural mips_cpu_ALU
    always_comb begin
        alu_res = 32'd0;
        case (o_alu_op)
            5'd0:  alu_res = o_alu_a & o_alu_b;
            5'd1:  alu_res = o_alu_a | o_alu_b;
            5'd2:  alu_res = o_alu_a + o_alu_b;
            5'd3:  alu_res = o_alu_a - o_alu_b;
            5'd4:  alu_res = {31'd0, $signed(o_alu_a) < $signed(o_alu_b)};
            5'd5:  alu_res = o_alu_a ^ o_alu_b;
            5'd6:  alu_res = o_alu_b << o_alu_sa;
            5'd7:  alu_res = o_alu_b >> o_alu_sa;
            5'd8:  alu_res = $signed(o_alu_b) >>> o_alu_sa;
            5'd9:  alu_res = o_alu_b << o_alu_a[4:0];
            5'd10: alu_res = o_alu_b >> o_alu_a[4:0];
            5'd11: alu_res = $signed(o_alu_b) >>> o_alu_a[4:0];
            5'd12: alu_res = {o_alu_b[15:0], 16'h0000};
            5'd13: alu_res = {31'd0, o_alu_a < o_alu_b};
            5'd14: alu_res = ~(o_alu_a | o_alu_b);
            5'd15: alu_res = o_alu_b;
            default: alu_res = 32'd0;
        endcase
    end
    assign alu_zero = (alu_res == 32'd0);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [4:0] sa,
                                          input logic [5:0] fn);
        return {6'h00, rs, rt, rd, sa, fn};
    endfunction

    function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    // Architectural reference for a legal ALU-class instruction
    function automatic exp_t ref_exec(input logic [31:0] ins, input logic [31:0] rs,
                                      input logic [31:0] rt);
        exp_t e;
        logic [31:0] simm;
        logic [31:0] zimm;
        logic [4:0]  sh;
        simm = {{16{ins[15]}}, ins[15:0]};
        zimm = {16'h0000, ins[15:0]};
        sh   = ins[10:6];
        e.rd = ins[20:16];
        e.data = 32'd0;
        if (ins[31:26] == 6'h00) begin
            e.rd = ins[15:11];
            case (ins[5:0])
                6'h20, 6'h21: e.data = rs + rt;
                6'h22, 6'h23: e.data = rs - rt;
                6'h24: e.data = rs & rt;
                6'h25: e.data = rs | rt;
                6'h26: e.data = rs ^ rt;
                6'h2A: e.data = ($signed(rs) < $signed(rt)) ? 32'd1 : 32'd0;
                6'h2B: e.data = (rs < rt) ? 32'd1 : 32'd0;
                6'h00: e.data = rt << sh;
                6'h02: e.data = rt >> sh;
                6'h03: e.data = $signed(rt) >>> sh;
                6'h04: e.data = rt << rs[4:0];
                6'h06: e.data = rt >> rs[4:0];
                6'h07: e.data = $signed(rt) >>> rs[4:0];
                default: e.data = 32'd0;
            endcase
        end else begin
            case (ins[31:26])
                6'h08, 6'h09: e.data = rs + simm;
                6'h0A: e.data = ($signed(rs) < $signed(simm)) ? 32'd1 : 32'd0;
                6'h0B: e.data = (rs < simm) ? 32'd1 : 32'd0;
                6'h0C: e.data = rs & zimm;
                6'h0D: e.data = rs | zimm;
                6'h0E: e.data = rs ^ zimm;
                6'h0F: e.data = {ins[15:0], 16'h0000};
                default: e.data = 32'd0;
            endcase
        end
        e.zero = (e.data == 32'd0);
        return e;
    endfunction

    // Offer one instruction, wait (bounded) for accept; returns on the negedge after the accepting edge.
    task automatic send(input logic [31:0] ins, input logic [31:0] rs, input logic [31:0] rt,
                        input bit legal);
        int n;
        i_instr_valid = 1'b1;
        i_instr       = ins;
        i_rs_data     = rs;
        i_rt_data     = rt;
        n = 0;
        #1;
        while (!o_instr_ready && n < 50) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (n >= 50) chk("accept_timeout", {31'd0, o_instr_ready}, 32'd1);
        if (legal) sb.push_back(ref_exec(ins, rs, rt));
        @(negedge clk);
        i_instr_valid = 1'b0;
    endtask

    // Writeback monitor: transfer completes at the next rising edge when valid && ready
    always begin
        exp_t e;
        @(negedge clk);
        #2;
        if (!i_reset && o_wb_valid && i_wb_ready) begin
            if (sb.size() == 0) begin
                chk("unexpected_wb", {27'd0, o_wb_reg}, 32'hFFFFFFFF);
            end else begin
                e = sb.pop_front();
                chk("wb_reg", {27'd0, o_wb_reg}, {27'd0, e.rd});
                chk("wb_data", o_wb_data, e.data);
                chk("wb_zero", {31'd0, o_wb_zero}, {31'd0, e.zero});
            end
        end
    end

    initial begin
        logic [31:0] held;
        i_reset = 1'b1;
        i_instr_valid = 1'b0;
        i_instr = 32'd0;
        i_rs_data = 32'd0;
        i_rt_data = 32'd0;
        i_wb_ready = 1'b1;
        repeat (2) @(negedge clk);

        // Reset state
        chk("rst_wb_valid", {31'd0, o_wb_valid}, 32'd0);
        chk("rst_illegal", {31'd0, o_illegal}, 32'd0);
        chk("rst_alu_op", {27'd0, o_alu_op}, 32'd0);
        chk("rst_alu_a", o_alu_a, 32'd0);
        chk("rst_alu_b", o_alu_b, 32'd0);
        chk("rst_alu_sa", {27'd0, o_alu_sa}, 32'd0);
        chk("rst_wb_reg", {27'd0, o_wb_reg}, 32'd0);
        chk("rst_wb_data", o_wb_data, 32'd0);
        chk("rst_wb_zero", {31'd0, o_wb_zero}, 32'd0);
        chk("rst_ready_low", {31'd0, o_instr_ready}, 32'd0);
        i_reset = 1'b0;
        @(negedge clk);
        chk("ready_after_rst", {31'd0, o_instr_ready}, 32'd1);

        // ADDU latency: wb after the second edge
        send(rtype(5'd1, 5'd2, 5'd3, 5'd0, 6'h21), 32'd5, 32'd7, 1'b1);
        chk("addu_alu_op", {27'd0, o_alu_op}, 32'd2);
        chk("addu_wb_early", {31'd0, o_wb_valid}, 32'd0);
        @(negedge clk);
        chk("addu_wb_valid", {31'd0, o_wb_valid}, 32'd1);
        chk("addu_wb_reg", {27'd0, o_wb_reg}, 32'd3);
        chk("addu_wb_data", o_wb_data, 32'd12);
        chk("addu_wb_zero", {31'd0, o_wb_zero}, 32'd0);
        repeat (2) @(negedge clk);

        // Back-to-back SLTI / SLTIU
        send(itype(6'h0A, 5'd1, 5'd4, 16'h0001), 32'hFFFFFFFF, 32'd0, 1'b1);
        send(itype(6'h0B, 5'd1, 5'd5, 16'hFFFF), 32'h00000005, 32'd0, 1'b1);
        chk("slti_wb_valid", {31'd0, o_wb_valid}, 32'd1);
        chk("slti_wb_data", o_wb_data, 32'd1);
        @(negedge clk);
        chk("sltiu_wb_valid", {31'd0, o_wb_valid}, 32'd1);
        chk("sltiu_wb_reg", {27'd0, o_wb_reg}, 32'd5);
        chk("sltiu_wb_data", o_wb_data, 32'd1);
        repeat (2) @(negedge clk);

        // Shifts, LUI, overflow wrap, zero flag, dest 0, zero-extended immediate
        send(rtype(5'd0, 5'd2, 5'd6, 5'd4, 6'h03), 32'd0, 32'h80000000, 1'b1);
        send(rtype(5'd1, 5'd2, 5'd7, 5'd0, 6'h07), 32'h00000024, 32'h80000000, 1'b1);
        send(itype(6'h0F, 5'd0, 5'd8, 16'hBEEF), 32'h12345678, 32'd0, 1'b1);
        send(rtype(5'd1, 5'd2, 5'd9, 5'd0, 6'h20), 32'h7FFFFFFF, 32'd1, 1'b1);
        send(rtype(5'd1, 5'd2, 5'd10, 5'd0, 6'h22), 32'd5, 32'd5, 1'b1);
        send(32'h00000000, 32'hAAAA5555, 32'h00001234, 1'b1);
        send(itype(6'h0C, 5'd1, 5'd11, 16'hFF00), 32'hFFFFFFFF, 32'd0, 1'b1);
        repeat (4) @(negedge clk);
        chk("drain_empty", sb.size(), 32'd0);

        // Back-pressure: two accepted, third blocked, wb holds steady
        i_wb_ready = 1'b0;
        send(rtype(5'd1, 5'd2, 5'd12, 5'd0, 6'h21), 32'd1, 32'd2, 1'b1);
        send(rtype(5'd1, 5'd2, 5'd13, 5'd0, 6'h25), 32'hF0, 32'h0F, 1'b1);
        i_instr_valid = 1'b1;
        i_instr = rtype(5'd1, 5'd2, 5'd14, 5'd0, 6'h26);
        i_rs_data = 32'hFF00FF00;
        i_rt_data = 32'h0FF00FF0;
        held = o_wb_data;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("bp_ready_low", {31'd0, o_instr_ready}, 32'd0);
            chk("bp_wb_valid", {31'd0, o_wb_valid}, 32'd1);
            chk("bp_wb_data", o_wb_data, 32'd3);
            chk("bp_wb_stable", o_wb_data, held);
            @(negedge clk);
        end
        i_wb_ready = 1'b1;
        send(rtype(5'd1, 5'd2, 5'd14, 5'd0, 6'h26), 32'hFF00FF00, 32'h0FF00FF0, 1'b1);
        chk("bp_rel_valid1", {31'd0, o_wb_valid}, 32'd1);
        chk("bp_rel_reg1", {27'd0, o_wb_reg}, 32'd13);
        @(negedge clk);
        chk("bp_rel_valid2", {31'd0, o_wb_valid}, 32'd1);
        chk("bp_rel_reg2", {27'd0, o_wb_reg}, 32'd14);
        repeat (3) @(negedge clk);

        // Illegal instruction: accepted, one-cycle pulse, no writeback
        send(32'hFC000000, 32'd1, 32'd2, 1'b0);
        chk("ill_pulse", {31'd0, o_illegal}, 32'd1);
        chk("ill_no_wb", {31'd0, o_wb_valid}, 32'd0);
        @(negedge clk);
        chk("ill_pulse_end", {31'd0, o_illegal}, 32'd0);
        chk("ill_no_wb2", {31'd0, o_wb_valid}, 32'd0);
        @(negedge clk);

        // Reset with both stages full
        i_wb_ready = 1'b0;
        send(rtype(5'd1, 5'd2, 5'd15, 5'd0, 6'h21), 32'd10, 32'd20, 1'b1);
        send(rtype(5'd1, 5'd2, 5'd16, 5'd0, 6'h21), 32'd30, 32'd40, 1'b1);
        chk("pre_rst_full", {31'd0, o_instr_ready}, 32'd0);
        i_reset = 1'b1;
        @(negedge clk);
        i_reset = 1'b0;
        sb.delete();
        #1;
        chk("mid_rst_wb_valid", {31'd0, o_wb_valid}, 32'd0);
        chk("mid_rst_ready", {31'd0, o_instr_ready}, 32'd1);
        chk("mid_rst_alu_op", {27'd0, o_alu_op}, 32'd0);
        @(negedge clk);
        i_wb_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("post_rst_no_wb", {31'd0, o_wb_valid}, 32'd0);
        end
        chk("final_sb_empty", sb.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mips_cpu_alu_issue.md
# mips_cpu_alu_issue

Decode-and-issue stage that drives `mips_cpu_ALU`. It accepts a register-sourced instruction word with operand values over a valid/ready handshake and decodes the ALU-class MIPS32 opcodes into the ALU's 5-bit op encoding plus operands. It launches the operation on the combinational ALU and registers the result as a writeback record for the register file. Two-stage pipeline (issue register, writeback register) with full back-pressure; sustains one instruction per cycle.

## Interface
- No parameters; widths fixed by the MIPS32 ISA.
- `clk` in 1: sole clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `instr_valid` in 1: instruction and operand data valid.
- `instr_ready` out 1: stage accepts this cycle.
- `instr` in 32: instruction word.
- `rs_data` in 32: GPR[rs] value.
- `rt_data` in 32: GPR[rt] value.
- `alu_op` out 5: ALU operation code.
- `alu_a` out 32: ALU operand a.
- `alu_b` out 32: ALU operand b.
- `alu_sa` out 5: ALU constant shift amount.
- `alu_result` in 32: ALU result, combinational from `alu_*`.
- `alu_zero` in 1: ALU zero flag.
- `wb_valid` out 1: writeback record valid.
- `wb_ready` in 1: register file consumes record.
- `wb_reg` out 5: destination GPR index.
- `wb_data` out 32: value to write.
- `wb_zero` out 1: captured `alu_zero`.
- `illegal` out 1: one-cycle pulse for an accepted non-ALU instruction.

## Operation
- R-type (opcode 0x00):
  - Decode on funct: 0x20/0x21→2, 0x22/0x23→3, 0x24→0, 0x25→1, 0x26→5, 0x2A→4, 0x2B→13.
  - Operands a=`rs_data`, b=`rt_data`, sa=0, dest=`instr[15:11]`.
- Constant shifts: funct 0x00→6, 0x02→7, 0x03→8. b=`rt_data`, sa=`instr[10:6]`, a=0.
- Variable shifts: funct 0x04→9, 0x06→10, 0x07→11. a=`rs_data` (ALU uses a[4:0]), b=`rt_data`, sa=0.
- I-type: dest=`instr[20:16]`, a=`rs_data`.
  - 0x08/0x09→2, sign-extended immediate.
  - 0x0A→4, sign-extended immediate.
  - 0x0B→13, sign-extended immediate (then compared unsigned).
  - 0x0C→0, 0x0D→1, 0x0E→5, zero-extended immediate.
  - 0x0F (LUI)→12, b=zero-extended immediate, a=0.
- ADD/SUB/ADDI do not trap on overflow; they behave identically to their unsigned forms.
- Illegal instructions:
  - Any other opcode/funct is consumed by the handshake but not loaded into the issue stage.
  - `illegal` pulses high the cycle after the accept.
- Destination 0 still produces a writeback (`wb_reg`=0); the register file discards it.

## Timing
- Handshakes:
  - Accept when `instr_valid && instr_ready`.
  - Writeback transfer when `wb_valid && wb_ready`.
- Latency:
  - Instruction accepted at edge N appears on `alu_*` after N.
  - `wb_valid` rises after edge N+1, given `wb_ready` was high or the wb stage was empty.
- Control equations:
  - `s1_adv = !wb_valid || wb_ready`
  - `instr_ready = !reset && (!s1_valid || s1_adv)`
- Wb capture:
  - When `s1_valid && s1_adv`, wb captures `alu_result`, `alu_zero` and the dest.
  - In the same edge, s1 reloads or clears.
- Stall: when wb is full and `wb_ready`=0, all registered outputs hold stable and `instr_ready`=0 once s1 is also full.
- Reset values:
  - `wb_valid`=0, `illegal`=0.
  - `alu_op`=0, `alu_a`=0, `alu_b`=0, `alu_sa`=0.
  - `wb_reg`=0, `wb_data`=0, `wb_zero`=0, s1_valid=0.
- Reset mid-operation drops both in-flight entries; no writeback for them is ever emitted.
- An illegal instruction accepted on the same edge that s1 drains leaves s1 empty.

## Structure
- Package `mips_cpu_pkg` holds:
  - ALU op enum (AND=0 … PASS_B=15, values matching the ALU).
  - Opcode and funct localparams.
  - Writeback record struct {reg, data, zero}.
- One natural sub-module: `mips_cpu_alu_decode`, a combinational map from instr/rs/rt to {op, a, b, sa, dest, legal}.
- The top holds the two pipeline registers and the handshake logic.
- The ALU is instantiated by the parent, not inside this block.

## Test plan
- ADDU: rs=5, rt=7, rd=3, `wb_ready`=1 → after 2 edges: `wb_valid`=1, `wb_reg`=3, `wb_data`=12, `wb_zero`=0.
- Back-to-back SLTI/SLTIU:
  - `SLTI` with rs=0xFFFFFFFF, imm=0x0001 gives 1.
  - `SLTIU` with rs=0x00000005, imm=0xFFFF gives 1.
  - Issued on consecutive cycles, they produce wb on consecutive cycles.
- Shifts:
  - SRA with rt=0x80000000, sa=4 gives 0xF8000000.
  - SRAV with rs=0x24, rt=0x80000000 gives 0xF8000000 (shift amount 4).
  - LUI imm=0xBEEF gives 0xBEEF0000.
- Back-pressure:
  - Hold `wb_ready`=0 with 3 instructions offered → 2 accepted, `instr_ready`=0, `wb_data` stable.
  - Release → remaining records emitted in order, one per cycle.
- Illegal: instr=0xFC000000 → accepted, `illegal` high exactly one cycle, no `wb_valid`.
- Reset mid-flight: assert `reset` for one cycle with both stages full → next cycle `wb_valid`=0, `instr_ready`=1, `alu_op`=0, no stale writeback.
